// File: rtl/ifid_hazard_pkg.sv
// Shared types and constants for the IF/ID hazard controller.
package ifid_hazard_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MUL_WAIT = 2'd2,
    ERR      = 2'd3
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/ifid_hazard_ctrl_hazard_match.sv
// Combinational hazard detection: load-use and branch-operand dependencies.
module hazard_match
  import ifid_hazard_pkg::*;
(
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UsesRt,
  input  logic       ID_Branch,
  input  logic       IDEX_MemRead,
  input  logic       IDEX_RegWrite,
  input  logic [4:0] IDEX_Rd,
  input  logic       EXMEM_MemRead,
  input  logic [4:0] EXMEM_Rd,
  output logic       LoadUse,
  output logic       BrHaz
);

  logic idex_hit;
  logic exmem_hit;

  // r0 is hardwired, so a write to it never creates a dependency
  assign idex_hit  = (IDEX_Rd != REG_ZERO) &
                     ((IDEX_Rd == ID_Rs) | (ID_UsesRt & (IDEX_Rd == ID_Rt)));
  assign exmem_hit = (EXMEM_Rd != REG_ZERO) &
                     ((EXMEM_Rd == ID_Rs) | (ID_UsesRt & (EXMEM_Rd == ID_Rt)));

  assign LoadUse = IDEX_MemRead & idex_hit;
  assign BrHaz   = ID_Branch & ((IDEX_RegWrite & idex_hit) | (EXMEM_MemRead & exmem_hit));

endmodule

// File: rtl/ifid_hazard_ctrl.sv
// IF/ID hazard controller: stall/flush/bubble sequencing, multi-cycle wait
// with watchdog, and saturating stall/flush performance counters.
module ifid_hazard_ctrl
  import ifid_hazard_pkg::*;
#(
  parameter int unsigned MUL_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_Branch,
  input  logic             ID_Jump,
  input  logic             BranchTaken,
  input  logic             MulStart,
  input  logic             IDEX_MemRead,
  input  logic             IDEX_RegWrite,
  input  logic [4:0]       IDEX_Rd,
  input  logic             EXMEM_MemRead,
  input  logic [4:0]       EXMEM_Rd,
  input  logic             MulDone,
  output logic             PCWrite,
  output logic             IFID_write,
  output logic             IF_flush,
  output logic             ID_bubble,
  output logic             Error,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int unsigned      WD_W    = $clog2(MUL_TIMEOUT);
  localparam logic [WD_W-1:0]  WD_LOAD = WD_W'(MUL_TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [WD_W-1:0] wd, wd_nxt;
  logic            load_use, br_haz, stall;
  logic            stall_inc, flush_inc;

  hazard_match u_match (
    .ID_Rs         (ID_Rs),
    .ID_Rt         (ID_Rt),
    .ID_UsesRt     (ID_UsesRt),
    .ID_Branch     (ID_Branch),
    .IDEX_MemRead  (IDEX_MemRead),
    .IDEX_RegWrite (IDEX_RegWrite),
    .IDEX_Rd       (IDEX_Rd),
    .EXMEM_MemRead (EXMEM_MemRead),
    .EXMEM_Rd      (EXMEM_Rd),
    .LoadUse       (load_use),
    .BrHaz         (br_haz)
  );

  assign stall = load_use | br_haz;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= INIT;
      wd    <= '0;
    end else begin
      state <= state_nxt;
      wd    <= wd_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    wd_nxt     = wd;
    PCWrite    = 1'b0;
    IFID_write = 1'b0;
    IF_flush   = 1'b0;
    ID_bubble  = 1'b1;
    unique case (state)
      INIT: state_nxt = RUN;
      RUN: begin
        if (stall) begin
          // hold PC and IF/ID, bubble into ID/EX
        end else if (ID_Jump | (ID_Branch & BranchTaken)) begin
          // flush only with IFID_write=0: the register prioritises write
          PCWrite   = 1'b1;
          IF_flush  = 1'b1;
          ID_bubble = 1'b0;
        end else if (MulStart) begin
          ID_bubble = 1'b0;
          wd_nxt    = WD_LOAD;
          state_nxt = MUL_WAIT;
        end else begin
          PCWrite    = 1'b1;
          IFID_write = 1'b1;
          ID_bubble  = 1'b0;
        end
      end
      MUL_WAIT: begin
        if (MulDone)         state_nxt = RUN;
        else if (wd == '0)   state_nxt = ERR;
        else                 wd_nxt    = wd - 1'b1;
      end
      ERR: state_nxt = ERR;
      default: state_nxt = INIT;
    endcase
  end

  assign Error     = (state == ERR);
  assign stall_inc = (state != INIT) & ~PCWrite & ~IF_flush;
  assign flush_inc = IF_flush;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      if (stall_inc && (StallCycles != '1)) StallCycles <= StallCycles + 1'b1;
      if (flush_inc && (FlushCount  != '1)) FlushCount  <= FlushCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// Scoreboard bench for ifid_hazard_ctrl: two instances (default sizing and a
// small watchdog/counter sizing) checked against a behavioural model.
module tb_ifid_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs, rt;
    logic       uses_rt, br, jmp, taken, mstart, idex_mr, idex_rw;
    logic [4:0] idex_rd;
    logic       exmem_mr;
    logic [4:0] exmem_rd;
    logic       mdone, rst_n;
  } stim_t;

  typedef struct packed {
    logic        pcw, ifw, fl, bub, err;
    logic [15:0] sc, fc;
  } exp_t;

  typedef struct packed {
    exp_t a, b;
  } sb_t;

  typedef struct {
    bit init, mul, err;
    int budget, stall, flush;
  } mdl_t;

  logic        Clk, Rst_n;
  logic [4:0]  ID_Rs, ID_Rt, IDEX_Rd, EXMEM_Rd;
  logic        ID_UsesRt, ID_Branch, ID_Jump, BranchTaken, MulStart;
  logic        IDEX_MemRead, IDEX_RegWrite, EXMEM_MemRead, MulDone;
  logic        pcw_a, ifw_a, fl_a, bub_a, err_a;
  logic        pcw_b, ifw_b, fl_b, bub_b, err_b;
  logic [15:0] sc_a, fc_a;
  logic [3:0]  sc_b, fc_b;

  ifid_hazard_ctrl #(.MUL_TIMEOUT(64), .CNT_W(16)) dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_Branch(ID_Branch), .ID_Jump(ID_Jump), .BranchTaken(BranchTaken),
    .MulStart(MulStart), .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite),
    .IDEX_Rd(IDEX_Rd), .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_Rd(EXMEM_Rd),
    .MulDone(MulDone), .PCWrite(pcw_a), .IFID_write(ifw_a), .IF_flush(fl_a),
    .ID_bubble(bub_a), .Error(err_a), .StallCycles(sc_a), .FlushCount(fc_a)
  );

  ifid_hazard_ctrl #(.MUL_TIMEOUT(4), .CNT_W(4)) dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_Branch(ID_Branch), .ID_Jump(ID_Jump), .BranchTaken(BranchTaken),
    .MulStart(MulStart), .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite),
    .IDEX_Rd(IDEX_Rd), .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_Rd(EXMEM_Rd),
    .MulDone(MulDone), .PCWrite(pcw_b), .IFID_write(ifw_b), .IF_flush(fl_b),
    .ID_bubble(bub_b), .Error(err_b), .StallCycles(sc_b), .FlushCount(fc_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  sb_t  q[$];
  mdl_t ma, mb;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc_no   = 0;

  function automatic mdl_t reset_mdl();
    mdl_t m;
    m.init = 1; m.mul = 0; m.err = 0;
    m.budget = 0; m.stall = 0; m.flush = 0;
    return m;
  endfunction

  function automatic bit hit(input logic [4:0] r, input stim_t s);
    return (r != 5'd0) && ((r == s.rs) || (s.uses_rt && (r == s.rt)));
  endfunction

  function automatic exp_t predict(input mdl_t m, input stim_t s, input int cmax);
    exp_t e;
    bit   haz, redir;
    e     = '0;
    e.bub = 1'b1;
    haz   = (s.idex_mr && hit(s.idex_rd, s)) ||
            (s.br && ((s.idex_rw && hit(s.idex_rd, s)) || (s.exmem_mr && hit(s.exmem_rd, s))));
    redir = s.jmp || (s.br && s.taken);
    if (!m.init && !m.mul && !m.err && !haz) begin
      if (redir)         begin e.pcw = 1; e.fl = 1; e.bub = 0; end
      else if (s.mstart) e.bub = 0;
      else               begin e.pcw = 1; e.ifw = 1; e.bub = 0; end
    end
    e.err = m.err;
    e.sc  = 16'((m.stall > cmax) ? cmax : m.stall);
    e.fc  = 16'((m.flush > cmax) ? cmax : m.flush);
    return e;
  endfunction

  function automatic mdl_t advance(input mdl_t m, input stim_t s, input exp_t e, input int tmo);
    mdl_t n = m;
    bit running = !m.init && !m.mul && !m.err;
    if (!s.rst_n) return m;
    if (!m.init && !e.pcw && !e.fl) n.stall++;
    if (e.fl) n.flush++;
    if (m.init) n.init = 0;
    else if (running && !e.pcw && !e.bub) begin
      // issued a multi-cycle op: it may spend at most tmo cycles waiting
      n.mul = 1; n.budget = tmo;
    end else if (m.mul) begin
      if (s.mdone) n.mul = 0;
      else begin
        n.budget--;
        if (n.budget == 0) begin n.mul = 0; n.err = 1; end
      end
    end
    return n;
  endfunction

  function automatic stim_t idle();
    stim_t s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  task automatic cyc(input stim_t s);
    sb_t ent;
    @(negedge Clk);
    ID_Rs = s.rs; ID_Rt = s.rt; ID_UsesRt = s.uses_rt; ID_Branch = s.br;
    ID_Jump = s.jmp; BranchTaken = s.taken; MulStart = s.mstart;
    IDEX_MemRead = s.idex_mr; IDEX_RegWrite = s.idex_rw; IDEX_Rd = s.idex_rd;
    EXMEM_MemRead = s.exmem_mr; EXMEM_Rd = s.exmem_rd; MulDone = s.mdone;
    Rst_n = s.rst_n;
    if (!s.rst_n) begin ma = reset_mdl(); mb = reset_mdl(); end
    ent.a = predict(ma, s, 65535);
    ent.b = predict(mb, s, 15);
    q.push_back(ent);
    ma = advance(ma, s, ent.a, 64);
    mb = advance(mb, s, ent.b, 4);
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) cyc(idle());
  endtask

  // Monitor: pops one expectation per cycle and compares mid-low-phase.
  initial begin
    sb_t  e;
    exp_t act;
    forever begin
      @(negedge Clk);
      #2;
      cyc_no++;
      if (q.size() > 0) begin
        e = q.pop_front();
        act = '{pcw: pcw_a, ifw: ifw_a, fl: fl_a, bub: bub_a, err: err_a, sc: sc_a, fc: fc_a};
        n_checks++;
        if (act == e.a) n_pass++;
        else $display("FAIL inst_a cyc=%0d actual pcw/ifw/fl/bub/err=%b%b%b%b%b sc=%0d fc=%0d required %b%b%b%b%b sc=%0d fc=%0d",
                      cyc_no, act.pcw, act.ifw, act.fl, act.bub, act.err, act.sc, act.fc,
                      e.a.pcw, e.a.ifw, e.a.fl, e.a.bub, e.a.err, e.a.sc, e.a.fc);
        act = '{pcw: pcw_b, ifw: ifw_b, fl: fl_b, bub: bub_b, err: err_b, sc: {12'd0, sc_b}, fc: {12'd0, fc_b}};
        n_checks++;
        if (act == e.b) n_pass++;
        else $display("FAIL inst_b cyc=%0d actual pcw/ifw/fl/bub/err=%b%b%b%b%b sc=%0d fc=%0d required %b%b%b%b%b sc=%0d fc=%0d",
                      cyc_no, act.pcw, act.ifw, act.fl, act.bub, act.err, act.sc, act.fc,
                      e.b.pcw, e.b.ifw, e.b.fl, e.b.bub, e.b.err, e.b.sc, e.b.fc);
      end
    end
  end

  initial begin
    stim_t s;
    ma = reset_mdl(); mb = reset_mdl();
    ID_Rs = '0; ID_Rt = '0; ID_UsesRt = 0; ID_Branch = 0; ID_Jump = 0; BranchTaken = 0;
    MulStart = 0; IDEX_MemRead = 0; IDEX_RegWrite = 0; IDEX_Rd = '0;
    EXMEM_MemRead = 0; EXMEM_Rd = '0; MulDone = 0; Rst_n = 0;

    // reset, then INIT cycle, then RUN
    s = idle(); s.rst_n = 0;
    cyc(s); cyc(s);
    idles(3);

    // load-use, then the same with r0 as destination
    s = idle(); s.idex_mr = 1; s.idex_rd = 5'd8; s.rs = 5'd8;
    cyc(s); idles(2);
    s.idex_rd = 5'd0;
    cyc(s); idles(2);

    // load feeding a branch: two stall cycles, then taken branch flushes
    s = idle(); s.br = 1; s.rs = 5'd9; s.idex_mr = 1; s.idex_rw = 1; s.idex_rd = 5'd9;
    cyc(s);
    s = idle(); s.br = 1; s.rs = 5'd9; s.exmem_mr = 1; s.exmem_rd = 5'd9;
    cyc(s);
    s = idle(); s.br = 1; s.rs = 5'd9; s.taken = 1;
    cyc(s); idles(2);

    // jump with a concurrent MulStart: flush wins; stray MulDone ignored
    s = idle(); s.jmp = 1; s.mstart = 1; s.mdone = 1;
    cyc(s); idles(2);

    // multi-cycle issue, done on 5th wait cycle (inst_b hits watchdog first)
    s = idle(); s.mstart = 1; cyc(s);
    idles(4);
    s = idle(); s.mdone = 1; cyc(s);
    idles(3);
    s = idle(); s.rst_n = 0; cyc(s);
    idles(3);

    // MulDone on the watchdog-zero cycle of inst_b
    s = idle(); s.mstart = 1; cyc(s);
    idles(3);
    s = idle(); s.mdone = 1; cyc(s);
    idles(3);

    // watchdog expiry on inst_b, frozen outputs, late MulDone, reset clears
    s = idle(); s.mstart = 1; cyc(s);
    idles(8);
    s = idle(); s.mdone = 1; s.jmp = 1; cyc(s);
    idles(3);
    s = idle(); s.rst_n = 0; s.mdone = 1; cyc(s);
    s = idle(); s.mdone = 1; cyc(s);
    idles(3);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s = idle();
      s.rs       = 5'($urandom_range(0, 3));
      s.rt       = 5'($urandom_range(0, 3));
      s.idex_rd  = 5'($urandom_range(0, 3));
      s.exmem_rd = 5'($urandom_range(0, 3));
      s.uses_rt  = ($urandom_range(0, 1) == 0);
      s.br       = ($urandom_range(0, 3) == 0);
      s.taken    = ($urandom_range(0, 1) == 0);
      s.jmp      = ($urandom_range(0, 7) == 0);
      s.mstart   = ($urandom_range(0, 7) == 0);
      s.idex_mr  = ($urandom_range(0, 3) == 0);
      s.idex_rw  = ($urandom_range(0, 2) == 0);
      s.exmem_mr = ($urandom_range(0, 3) == 0);
      s.mdone    = ($urandom_range(0, 9) == 0);
      s.rst_n    = ($urandom_range(0, 299) != 0);
      cyc(s);
    end

    // saturation of the 16-bit stall counter: park in MUL_WAIT/ERR
    s = idle(); s.rst_n = 0; cyc(s);
    idles(2);
    s = idle(); s.mstart = 1; cyc(s);
    idles(65600);
    s = idle(); s.rst_n = 0; cyc(s);
    idles(3);

    repeat (3) @(negedge Clk);
    #4;
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain actual=%0d pending required=0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ifid_hazard_ctrl.md
# ifid_hazard_ctrl

Pipeline hazard controller that sequences the IF/ID pipeline register and the PC. It drives the register's write-enable and flush inputs, the PC write-enable, and the ID/EX bubble select. It resolves load-use and branch-operand stalls, taken-branch and jump flushes, and multi-cycle (multiply/divide) issue waits, with a watchdog. It sits in the ID stage, between the hazard sources (ID/EX, EX/MEM, and the multi-cycle unit) and the fetch-side registers.

## Interface
- MUL_TIMEOUT, 64: maximum cycles spent in MUL_WAIT before the block flags an error; must be ≥2.
- CNT_W, 16: width of the saturating performance counters.

Ports:
- Clk  in  1  clock; rising edge.
- Rst_n  in  1  reset; asynchronous, active-low.
- ID_Rs, ID_Rt  in  5 each  source registers of the instruction in ID.
- ID_UsesRt  in  1  ID instruction reads Rt.
- ID_Branch, ID_Jump  in  1 each  ID instruction is a conditional branch or a jump.
- BranchTaken  in  1  branch comparison result in ID; valid only when ID_Branch=1.
- MulStart  in  1  ID instruction is multi-cycle.
- IDEX_MemRead, IDEX_RegWrite  in  1 each  control bits of the instruction in EX.
- IDEX_Rd  in  5  resolved destination register in EX.
- EXMEM_MemRead  in  1  instruction in MEM is a load.
- EXMEM_Rd  in  5  destination register in MEM.
- MulDone  in  1  one-cycle pulse from the multi-cycle unit.
- PCWrite  out  1  PC update enable.
- IFID_write  out  1  IF/ID register load enable.
- IF_flush  out  1  IF/ID register zero (inserts a NOP).
- ID_bubble  out  1  zero the control bits entering ID/EX.
- Error  out  1  sticky watchdog flag.
- StallCycles, FlushCount  out  CNT_W each  saturating performance counters.

## Operation
- States: INIT, RUN, MUL_WAIT, ERR.
- A hazard match requires the destination register to be nonzero.
- match(r) = (r == ID_Rs) | (ID_UsesRt & r == ID_Rt).
- LoadUse = IDEX_MemRead & match(IDEX_Rd).
- BrHaz = ID_Branch & ((IDEX_RegWrite & match(IDEX_Rd)) | (EXMEM_MemRead & match(EXMEM_Rd))).
- Stall = LoadUse | BrHaz.
- INIT:
  - Outputs: PCWrite=0, IFID_write=0, IF_flush=0, ID_bubble=1.
  - Always moves to RUN on the next edge.
- RUN, priority order:
  1. Stall: PCWrite=0, IFID_write=0, IF_flush=0, ID_bubble=1. Stall conditions are re-evaluated every cycle, so a load feeding a branch stalls 2 cycles.
  2. ID_Jump, or ID_Branch & BranchTaken: PCWrite=1, IFID_write=0, IF_flush=1, ID_bubble=0.
  3. MulStart: the instruction issues (ID_bubble=0). PCWrite=0, IFID_write=0. Load the watchdog with MUL_TIMEOUT-1 and go to MUL_WAIT.
  4. Otherwise: PCWrite=1, IFID_write=1, IF_flush=0, ID_bubble=0.
- IF_flush=1 only ever occurs with IFID_write=0, because the IF/ID register gives write priority over flush.
- MUL_WAIT:
  - Outputs: PCWrite=0, IFID_write=0, IF_flush=0, ID_bubble=1.
  - MulDone=1: go to RUN.
  - Otherwise, watchdog == 0: go to ERR.
  - Otherwise: decrement the watchdog.
- MulDone in any state other than MUL_WAIT is ignored.
- ERR: same outputs as MUL_WAIT, with Error=1. Only reset leaves ERR.
- StallCycles increments on every cycle with PCWrite=0 & IF_flush=0, in every state except INIT.
- FlushCount increments on every cycle with IF_flush=1.
- Both counters saturate at all ones and never wrap.

## Timing
- All outputs except the counters are combinational from state and current inputs. The counters are registered.
- Reset asserted (asynchronous): state=INIT, watchdog=0, counters=0, Error=0. Outputs are therefore PCWrite=0, IFID_write=0, IF_flush=0, ID_bubble=1.
- After reset deasserts, the first edge moves the block INIT→RUN.
- Reset asserted mid MUL_WAIT or in ERR: the block returns to INIT immediately. A late MulDone is then ignored.
- Flush latency: IF_flush is asserted in the same cycle that BranchTaken or ID_Jump is seen in RUN. The IF/ID register holds a NOP after that edge.
- MulDone arriving on the same cycle that the watchdog reaches 0: MulDone wins, next state is RUN, Error stays 0.
- Counter increments become visible one cycle after the event.

## Structure
- Shared package ifid_hazard_pkg holds:
  - the state enum (INIT=2'd0, RUN=2'd1, MUL_WAIT=2'd2, ERR=2'd3);
  - the REG_ZERO=5'd0 constant.
- One natural sub-module: hazard_match. It is purely combinational and produces LoadUse and BrHaz.
- The top level holds the FSM, watchdog and counters.

## Test plan
- Reset release: Rst_n 0→1. Before the first edge, PCWrite=0 and ID_bubble=1. After the first edge, with no hazards, PCWrite=1 and IFID_write=1. Counters read 0.
- Load-use: IDEX_MemRead=1, IDEX_Rd=8, ID_Rs=8 for 1 cycle → exactly 1 cycle with IFID_write=0 and ID_bubble=1; StallCycles=1. Repeat with IDEX_Rd=0 → no stall.
- Load feeding a branch: ID_Branch=1, ID_Rs=9. Cycle 1: IDEX_MemRead=1, IDEX_RegWrite=1, IDEX_Rd=9. Cycle 2: EXMEM_MemRead=1, EXMEM_Rd=9. Required: 2 stall cycles, then BranchTaken=1 → IF_flush=1 with IFID_write=0; FlushCount=1.
- Multi-cycle issue: MulStart=1, MulDone pulsed 5 cycles later → 5 MUL_WAIT cycles with PCWrite=0, then RUN; StallCycles=6.
- Watchdog: MUL_TIMEOUT=4, MulStart=1, no MulDone → Error=1 after 4 MUL_WAIT cycles; outputs stay frozen; Rst_n pulse clears Error.
- Boundary: MulDone on the watchdog-zero cycle → RUN, Error=0. Force StallCycles near saturation → it holds at 16'hFFFF and does not wrap.
